// File: rtl/display_pager_if.sv
// if_date_time: BCD date/time fields published by the DCF77 clock module.
//   second, minute, hour, day, month, year : two BCD digits each (8 bits)
//   day_of_week                            : 0 = unknown, 1 = Monday .. 7 = Sunday
// Modports:
//   src  - the clock module drives every field
//   sink - consumers such as display_pager only read
interface if_date_time;
  logic [7:0] second;
  logic [7:0] minute;
  logic [7:0] hour;
  logic [7:0] day;
  logic [7:0] month;
  logic [7:0] year;
  logic [2:0] day_of_week;

  modport src  (output second, minute, hour, day, month, year, day_of_week);
  modport sink (input  second, minute, hour, day, month, year, day_of_week);
endinterface

// File: rtl/display_pager.sv
// display_pager: time-multiplexed seven-segment driver for the DCF77 date/time.
// A coherent shadow copy of the clock fields is captured on every tick_1hz.
// A page of that copy is chosen either from the switches or by auto-rotation.
// Digits are scanned one at a time onto shared active-low segment lines.
// The display blinks at 0.5 Hz while the receiver is not synchronised.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   tick_1hz    one-cycle pulse per second
//   sync_valid  1 = DCF77 time synchronised (blinking suppressed)
//   auto_en     1 = auto-rotate pages, 0 = manual selection via SW
//   SW[2:0]     manual page select, SW[0] has highest priority
//   clock       if_date_time sink with the live BCD fields
//   SEG[6:0]    segments GFEDCBA, active-low, registered
//   AN[N-1:0]   digit enables, one-hot active-low, AN[0] is the rightmost digit
//   page[1:0]   page currently displayed, registered
//   dbg_mode_o  mode FSM state, 1 = AUTO, 0 = MANUAL
module display_pager #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLANK_CYC  = 2,
  parameter int ROTATE_S   = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick_1hz,
  input  logic                  sync_valid,
  input  logic                  auto_en,
  input  logic [2:0]            SW,
  if_date_time.sink             clock,
  output logic [6:0]            SEG,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [1:0]            page,
  output logic                  dbg_mode_o
);

  localparam int DIV       = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int PW        = $clog2(DIV);
  localparam int DW        = $clog2(NUM_DIGITS);
  localparam int NUM_PAGES = (NUM_DIGITS == 6) ? 3 : 4;
  localparam int RW        = (ROTATE_S > 1) ? $clog2(ROTATE_S) : 1;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_e;

  // Glyph tables are written active-high (gfedcba) for readability and
  // inverted on the way out.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] on;
    case (n)
      4'h0: on = 7'h3F;
      4'h1: on = 7'h06;
      4'h2: on = 7'h5B;
      4'h3: on = 7'h4F;
      4'h4: on = 7'h66;
      4'h5: on = 7'h6D;
      4'h6: on = 7'h7D;
      4'h7: on = 7'h07;
      4'h8: on = 7'h7F;
      4'h9: on = 7'h6F;
      4'hA: on = 7'h77;
      4'hB: on = 7'h7C;
      4'hC: on = 7'h39;
      4'hD: on = 7'h5E;
      4'hE: on = 7'h79;
      default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  // Two-character weekday names: "--", Mo, tu, WE, th, Fr, SA, So.
  // M and W are approximated by an inverted U and a U respectively.
  function automatic logic [6:0] wd_glyph(input logic [2:0] wd, input logic left);
    logic [13:0] pair;
    case (wd)
      3'd0: pair = {7'h40, 7'h40};
      3'd1: pair = {7'h37, 7'h5C};
      3'd2: pair = {7'h78, 7'h1C};
      3'd3: pair = {7'h3E, 7'h79};
      3'd4: pair = {7'h78, 7'h74};
      3'd5: pair = {7'h71, 7'h50};
      3'd6: pair = {7'h6D, 7'h77};
      default: pair = {7'h6D, 7'h5C};
    endcase
    return left ? ~pair[13:7] : ~pair[6:0];
  endfunction

  // Shadow copy of the clock fields
  logic [7:0] sec_q, min_q, hour_q, day_q, mon_q, year_q;
  logic [2:0] wd_q;

  // Scan state
  logic [PW-1:0]         presc_q, presc_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  // Page / mode state
  mode_e         mode_q, mode_d;
  logic [1:0]    page_q, page_d;
  logic [RW-1:0] dwell_q, dwell_d;
  logic [1:0]    sw_page;

  // Blink and segment output
  logic       phase_q, phase_d;
  logic       blank_now;
  logic [6:0] glyph;
  logic [6:0] seg_q, seg_d;

  assign SEG        = seg_q;
  assign AN         = an_q;
  assign page       = page_q;
  assign dbg_mode_o = (mode_q == AUTO);

  // Scan: AN is computed from the next prescaler/digit values so that the
  // registered AN lines up with the prescaler count it describes.
  always_comb begin
    presc_d = presc_q + 1'b1;
    digit_d = digit_q;
    if (presc_q == PW'(DIV - 1)) begin
      presc_d = '0;
      digit_d = (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end
    an_d = '1;
    if (presc_d >= PW'(BLANK_CYC)) an_d[digit_d] = 1'b0;
  end

  // Manual page decode, SW[0] > SW[1] > SW[2] > none
  always_comb begin
    sw_page = 2'd0;
    if (NUM_DIGITS == 6) begin
      if (SW[0])      sw_page = 2'd0;
      else if (SW[1]) sw_page = 2'd1;
      else if (SW[2]) sw_page = 2'd2;
    end else begin
      if (SW[0])      sw_page = 2'd1;
      else if (SW[1]) sw_page = 2'd2;
      else if (SW[2]) sw_page = 2'd3;
    end
  end

  // Mode FSM: the MANUAL->AUTO transition is the auto_en rising edge, so a
  // tick arriving on that same cycle restarts rotation instead of counting.
  always_comb begin
    mode_d  = mode_q;
    page_d  = page_q;
    dwell_d = dwell_q;
    case (mode_q)
      MANUAL: begin
        dwell_d = '0;
        if (auto_en) begin
          mode_d = AUTO;
          page_d = 2'd0;
        end else begin
          page_d = sw_page;
        end
      end
      AUTO: begin
        if (!auto_en) begin
          mode_d  = MANUAL;
          page_d  = sw_page;
          dwell_d = '0;
        end else if (tick_1hz) begin
          if (dwell_q == RW'(ROTATE_S - 1)) begin
            dwell_d = '0;
            page_d  = (page_q == 2'(NUM_PAGES - 1)) ? 2'd0 : page_q + 2'd1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
    endcase
  end

  // sync_valid overrides the blink phase in the same cycle, so the display
  // returns to normal on the first edge after synchronisation.
  always_comb begin
    phase_d = phase_q;
    if (sync_valid)    phase_d = 1'b0;
    else if (tick_1hz) phase_d = ~phase_q;
  end

  assign blank_now = phase_q & ~sync_valid;

  // Glyph for the digit currently being scanned, taken from the shadow copy.
  always_comb begin
    glyph = SEG_BLANK;
    if (NUM_DIGITS == 6) begin
      case (page_q)
        2'd0: begin
          case (int'(digit_q))
            0: glyph = hex_glyph(sec_q[3:0]);
            1: glyph = hex_glyph(sec_q[7:4]);
            2: glyph = hex_glyph(min_q[3:0]);
            3: glyph = hex_glyph(min_q[7:4]);
            4: glyph = hex_glyph(hour_q[3:0]);
            5: glyph = hex_glyph(hour_q[7:4]);
            default: glyph = SEG_BLANK;
          endcase
        end
        2'd1: begin
          case (int'(digit_q))
            0: glyph = hex_glyph(mon_q[3:0]);
            1: glyph = hex_glyph(mon_q[7:4]);
            2: glyph = hex_glyph(day_q[3:0]);
            3: glyph = hex_glyph(day_q[7:4]);
            4: glyph = wd_glyph(wd_q, 1'b0);
            5: glyph = wd_glyph(wd_q, 1'b1);
            default: glyph = SEG_BLANK;
          endcase
        end
        2'd2: begin
          // Year shown as 20YY with the two leftmost digits dark
          case (int'(digit_q))
            0: glyph = hex_glyph(year_q[3:0]);
            1: glyph = hex_glyph(year_q[7:4]);
            2: glyph = hex_glyph(4'h0);
            3: glyph = hex_glyph(4'h2);
            default: glyph = SEG_BLANK;
          endcase
        end
        default: glyph = SEG_BLANK;
      endcase
    end else begin
      case (page_q)
        2'd0: begin
          case (int'(digit_q))
            0: glyph = hex_glyph(min_q[3:0]);
            1: glyph = hex_glyph(min_q[7:4]);
            2: glyph = hex_glyph(hour_q[3:0]);
            default: glyph = hex_glyph(hour_q[7:4]);
          endcase
        end
        2'd1: begin
          case (int'(digit_q))
            0: glyph = hex_glyph(sec_q[3:0]);
            1: glyph = hex_glyph(sec_q[7:4]);
            default: glyph = hex_glyph(4'h0);
          endcase
        end
        2'd2: begin
          case (int'(digit_q))
            0: glyph = hex_glyph(day_q[3:0]);
            1: glyph = hex_glyph(day_q[7:4]);
            2: glyph = wd_glyph(wd_q, 1'b0);
            default: glyph = wd_glyph(wd_q, 1'b1);
          endcase
        end
        default: begin
          case (int'(digit_q))
            0: glyph = hex_glyph(mon_q[3:0]);
            1: glyph = hex_glyph(mon_q[7:4]);
            2: glyph = hex_glyph(year_q[3:0]);
            default: glyph = hex_glyph(year_q[7:4]);
          endcase
        end
      endcase
    end
  end

  assign seg_d = blank_now ? SEG_BLANK : glyph;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      day_q   <= '0;
      mon_q   <= '0;
      year_q  <= '0;
      wd_q    <= '0;
      presc_q <= '0;
      digit_q <= '0;
      an_q    <= '1;
      mode_q  <= MANUAL;
      page_q  <= 2'd0;
      dwell_q <= '0;
      phase_q <= 1'b0;
      seg_q   <= SEG_BLANK;
    end else begin
      if (tick_1hz) begin
        sec_q  <= clock.second;
        min_q  <= clock.minute;
        hour_q <= clock.hour;
        day_q  <= clock.day;
        mon_q  <= clock.month;
        year_q <= clock.year;
        wd_q   <= clock.day_of_week;
      end
      presc_q <= presc_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      mode_q  <= mode_d;
      page_q  <= page_d;
      dwell_q <= dwell_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

endmodule

// File: tb/tb_display_pager.sv
// tb_display_pager: bench for display_pager with a 4-digit instance
// (DIV = 8, BLANK_CYC = 2, ROTATE_S = 2) and a 6-digit instance (DIV = 8).
module tb_display_pager;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst4_n, rst6_n;
  logic       tick, sync_valid, auto_en;
  logic [2:0] sw;
  logic [6:0] seg4, seg6;
  logic [3:0] an4;
  logic [5:0] an6;
  logic [1:0] page4, page6;
  logic       mode4, mode6;

  if_date_time dt();

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Expected glyphs, active-low GFEDCBA
  logic [6:0] hx  [16];
  logic [6:0] wdl [8];
  logic [6:0] wdr [8];

  display_pager #(
    .NUM_DIGITS(4), .CLK_HZ(32000), .SCAN_HZ(1000), .BLANK_CYC(2), .ROTATE_S(2)
  ) dut4 (
    .clk(clk), .reset_n(rst4_n), .tick_1hz(tick), .sync_valid(sync_valid),
    .auto_en(auto_en), .SW(sw), .clock(dt), .SEG(seg4), .AN(an4),
    .page(page4), .dbg_mode_o(mode4)
  );

  display_pager #(
    .NUM_DIGITS(6), .CLK_HZ(48000), .SCAN_HZ(1000), .BLANK_CYC(2), .ROTATE_S(5)
  ) dut6 (
    .clk(clk), .reset_n(rst6_n), .tick_1hz(tick), .sync_valid(sync_valid),
    .auto_en(auto_en), .SW(sw), .clock(dt), .SEG(seg6), .AN(an6),
    .page(page6), .dbg_mode_o(mode6)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push4(input logic [6:0] d3, input logic [6:0] d2,
                       input logic [6:0] d1, input logic [6:0] d0);
    exp_q.push_back({1'b0, d3});
    exp_q.push_back({1'b0, d2});
    exp_q.push_back({1'b0, d1});
    exp_q.push_back({1'b0, d0});
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic set_sw(input logic [2:0] v);
    sw = v;
    repeat (2) @(negedge clk);
  endtask

  // Returns at the first cycle of the next window where AN equals pat.
  task automatic wait_an4(input logic [3:0] pat);
    int n = 0;
    while (an4 == pat && n < 100) begin @(negedge clk); n++; end
    while (an4 != pat && n < 100) begin @(negedge clk); n++; end
    if (an4 != pat) check("an4_wait", {4'b0, an4}, {4'b0, pat});
  endtask

  task automatic wait_an6(input logic [5:0] pat);
    int n = 0;
    while (an6 == pat && n < 150) begin @(negedge clk); n++; end
    while (an6 != pat && n < 150) begin @(negedge clk); n++; end
    if (an6 != pat) check("an6_wait", {2'b0, an6}, {2'b0, pat});
  endtask

  // Reads digits 3..0 off the 4-digit display against the expected queue.
  task automatic scan4(input string tag);
    logic [3:0] pat;
    for (int d = 3; d >= 0; d--) begin
      pat = ~(4'b0001 << d);
      wait_an4(pat);
      check($sformatf("%s_d%0d", tag, d), {1'b0, seg4}, exp_q.pop_front());
    end
  endtask

  task automatic scan6(input string tag);
    logic [5:0] pat;
    for (int d = 5; d >= 0; d--) begin
      pat = ~(6'b000001 << d);
      wait_an6(pat);
      check($sformatf("%s_d%0d", tag, d), {1'b0, seg6}, exp_q.pop_front());
    end
  endtask

  initial begin
    hx  = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    wdl = '{7'h3F, 7'h48, 7'h07, 7'h41, 7'h07, 7'h0E, 7'h12, 7'h12};
    wdr = '{7'h3F, 7'h23, 7'h63, 7'h06, 7'h0B, 7'h2F, 7'h08, 7'h23};

    // Reset
    rst4_n = 1'b0;
    rst6_n = 1'b0;
    tick = 1'b0;
    sync_valid = 1'b1;
    auto_en = 1'b0;
    sw = 3'b000;
    dt.second = 8'h00; dt.minute = 8'h00; dt.hour = 8'h00;
    dt.day = 8'h00; dt.month = 8'h00; dt.year = 8'h00; dt.day_of_week = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_seg4", {1'b0, seg4}, 8'h7F);
    check("rst_an4", {4'b0, an4}, 8'h0F);
    check("rst_page4", {6'b0, page4}, 8'h00);
    check("rst_mode4", {7'b0, mode4}, 8'h00);
    check("rst_seg6", {1'b0, seg6}, 8'h7F);
    check("rst_an6", {2'b0, an6}, 8'h3F);

    // Scan sequence after release: expected AN per cycle
    rst4_n = 1'b1;
    rst6_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int p, dg;
      logic [3:0] e;
      p  = k % 8;
      dg = (k / 8) % 4;
      e  = (p < 2) ? 4'hF : ~(4'b0001 << dg);
      exp_q.push_back({4'b0, e});
    end
    for (int k = 0; k < 40; k++) begin
      check($sformatf("scan_an_k%0d", k), {4'b0, an4}, exp_q.pop_front());
      @(negedge clk);
    end

    // Manual pages, clock 12:34:56 Fr 17.05.24
    dt.hour = 8'h12; dt.minute = 8'h34; dt.second = 8'h56;
    dt.day = 8'h17; dt.month = 8'h05; dt.year = 8'h24; dt.day_of_week = 3'd5;
    pulse_tick();
    set_sw(3'b000);
    check("man_page0", {6'b0, page4}, 8'd0);
    push4(hx[1], hx[2], hx[3], hx[4]);
    scan4("man_p0");
    set_sw(3'b011);
    check("man_page1", {6'b0, page4}, 8'd1);
    push4(hx[0], hx[0], hx[5], hx[6]);
    scan4("man_p1");
    set_sw(3'b010);
    check("man_page2", {6'b0, page4}, 8'd2);
    push4(wdl[5], wdr[5], hx[1], hx[7]);
    scan4("man_p2");
    set_sw(3'b100);
    check("man_page3", {6'b0, page4}, 8'd3);
    push4(hx[2], hx[4], hx[0], hx[5]);
    scan4("man_p3");

    // SW change shows on page exactly one cycle later
    sw = 3'b001;
    @(negedge clk);
    check("sw_lat1", {6'b0, page4}, 8'd1);

    // Every weekday glyph pair on page 2
    set_sw(3'b010);
    for (int w = 0; w < 8; w++) begin
      dt.day_of_week = 3'(w);
      pulse_tick();
      push4(wdl[w], wdr[w], hx[1], hx[7]);
      scan4($sformatf("wd%0d", w));
    end

    // Snapshot coherence: a field change without a tick is not shown
    set_sw(3'b000);
    dt.minute = 8'h35;
    push4(hx[1], hx[2], hx[3], hx[4]);
    scan4("snap_old");
    wait_an4(4'b1110);
    exp_q.push_back({1'b0, hx[4]});
    exp_q.push_back({1'b0, hx[5]});
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("snap_t1", {1'b0, seg4}, exp_q.pop_front());
    @(negedge clk);
    check("snap_t2", {1'b0, seg4}, exp_q.pop_front());

    // Hex glyphs for non-BCD nibbles
    dt.hour = 8'hCD; dt.minute = 8'hEF; dt.second = 8'hAB;
    pulse_tick();
    push4(hx[12], hx[13], hx[14], hx[15]);
    scan4("hex_p0");
    set_sw(3'b001);
    push4(hx[0], hx[0], hx[10], hx[11]);
    scan4("hex_p1");

    // Auto rotation
    set_sw(3'b100);
    check("pre_auto_page", {6'b0, page4}, 8'd3);
    auto_en = 1'b1;
    @(negedge clk);
    check("auto_rise_page", {6'b0, page4}, 8'd0);
    check("auto_mode", {7'b0, mode4}, 8'd1);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    exp_q.push_back(8'd3); exp_q.push_back(8'd0);
    for (int t = 1; t <= 8; t++) begin
      pulse_tick();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check($sformatf("auto_tick%0d", t), {6'b0, page4}, exp_q.pop_front());
    end
    pulse_tick();
    check("auto_dwell1", {6'b0, page4}, 8'd0);

    // auto_en fall: page follows SW next cycle
    auto_en = 1'b0;
    @(negedge clk);
    check("fall_sw", {6'b0, page4}, 8'd3);
    check("fall_mode", {7'b0, mode4}, 8'd0);

    // Tick coincident with auto_en rise: page 0, dwell 0, snapshot updates
    dt.hour = 8'h13; dt.minute = 8'h35; dt.second = 8'h56;
    auto_en = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("coinc_page", {6'b0, page4}, 8'd0);
    pulse_tick();
    check("coinc_dwell", {6'b0, page4}, 8'd0);
    pulse_tick();
    check("coinc_adv", {6'b0, page4}, 8'd1);
    auto_en = 1'b0;
    set_sw(3'b000);
    check("back_manual", {6'b0, page4}, 8'd0);
    push4(hx[1], hx[3], hx[3], hx[5]);
    scan4("coinc_snap");

    // Blink while not synchronised
    sync_valid = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      pulse_tick();
      if (t % 2 == 1) push4(7'h7F, 7'h7F, 7'h7F, 7'h7F);
      else            push4(hx[1], hx[3], hx[3], hx[5]);
      scan4($sformatf("blink%0d", t));
    end
    pulse_tick();
    wait_an4(4'b1110);
    exp_q.push_back(8'h7F);
    exp_q.push_back({1'b0, hx[5]});
    check("blink_blank", {1'b0, seg4}, exp_q.pop_front());
    sync_valid = 1'b1;
    @(negedge clk);
    check("sync_restore", {1'b0, seg4}, exp_q.pop_front());

    // 6-digit instance
    dt.hour = 8'h23; dt.minute = 8'h59; dt.second = 8'h58;
    dt.year = 8'h24; dt.day_of_week = 3'd5;
    sw = 3'b100;
    pulse_tick();
    @(negedge clk);
    check("d6_page2", {6'b0, page6}, 8'd2);
    exp_q.push_back(8'h7F); exp_q.push_back(8'h7F);
    exp_q.push_back({1'b0, hx[2]}); exp_q.push_back({1'b0, hx[0]});
    exp_q.push_back({1'b0, hx[2]}); exp_q.push_back({1'b0, hx[4]});
    scan6("d6_p2");
    set_sw(3'b000);
    check("d6_page0", {6'b0, page6}, 8'd0);
    exp_q.push_back({1'b0, hx[2]}); exp_q.push_back({1'b0, hx[3]});
    exp_q.push_back({1'b0, hx[5]}); exp_q.push_back({1'b0, hx[9]});
    exp_q.push_back({1'b0, hx[5]}); exp_q.push_back({1'b0, hx[8]});
    scan6("d6_p0");
    set_sw(3'b010);
    check("d6_page1", {6'b0, page6}, 8'd1);
    exp_q.push_back({1'b0, wdl[5]}); exp_q.push_back({1'b0, wdr[5]});
    exp_q.push_back({1'b0, hx[1]});  exp_q.push_back({1'b0, hx[7]});
    exp_q.push_back({1'b0, hx[0]});  exp_q.push_back({1'b0, hx[5]});
    scan6("d6_p1");

    // Asynchronous reset mid-scan
    wait_an6(6'b111011);
    #2;
    rst6_n = 1'b0;
    #1;
    check("arst_seg6", {1'b0, seg6}, 8'h7F);
    check("arst_an6", {2'b0, an6}, 8'h3F);
    check("arst_page6", {6'b0, page6}, 8'd0);
    @(negedge clk);
    rst6_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
